// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_subtractor
// Description : Multi-cycle WIDTH-bit subtractor (diff = a - b - bin). One
//               4-bit slice is handled per clock by a carry-look-ahead adder
//               computing a + ~b + ~borrow. Uses a start/busy/done handshake
//               and registers diff, borrow_out and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_partial;
  logic             r_carry;
  logic [IW-1:0]    r_idx;

  logic [3:0]       w_sa;
  logic [3:0]       w_sb;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_s;
  logic [WIDTH-1:0] w_full;
  logic             w_last;

  assign w_last = (r_idx == IW'(NIB - 1));

  // Current slice operands and 4-bit CLA for a + ~b + carry.
  always_comb begin
    w_sa   = r_a[4*int'(r_idx) +: 4];
    w_sb   = r_b[4*int'(r_idx) +: 4];
    w_g    = w_sa & ~w_sb;
    w_p    = w_sa ^ ~w_sb;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & r_carry);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_s    = w_p ^ w_c[3:0];
  end

  // Partial result with the slice being computed this cycle merged in.
  always_comb begin
    w_full                      = r_partial;
    w_full[4*int'(r_idx) +: 4]  = w_s;
  end

  // Next-state logic: accept start in IDLE, return after the last slice.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand latch, slice iteration and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_partial  <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= ~bin;
            r_idx   <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          r_partial <= w_full;
          r_carry   <= w_c[4];
          r_idx     <= r_idx + 1'b1;
          if (w_last) begin
            diff       <= w_full;
            borrow_out <= ~w_c[4];
            overflow   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_full[WIDTH-1] != r_a[WIDTH-1]);
            done       <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_subtractor
// Description : Self-checking bench for nibble_serial_subtractor (WIDTH=16):
//               directed vector table, handshake corner sequences and random
//               operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_subtractor;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic        bin   = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow_out;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present operands with start; returns at the falling edge after acceptance.
  task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
    @(negedge clk);
    a = va; b = vb; bin = vbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed,
                              input logic eb, input logic eo);
    check({tag, ".diff"},   {16'h0, diff},        {16'h0, ed});
    check({tag, ".borrow"}, {31'h0, borrow_out},  {31'h0, eb});
    check({tag, ".ovf"},    {31'h0, overflow},    {31'h0, eo});
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                       output logic [15:0] ed, output logic eb, output logic eo);
    int ud;
    int sa;
    int sb;
    int sd;
    ud = int'(va) - int'(vb) - int'(vbin);
    sa = $signed(va);
    sb = $signed(vb);
    sd = sa - sb - int'(vbin);
    ed = ud[15:0];
    eb = (ud < 0);
    eo = (sd < -32768) || (sd > 32767);
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [15:0] ra, rb, ed;
    logic        rbin, eb, eo;

    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy",   {31'h0, busy},       32'h0);
    check("rst.done",   {31'h0, done},       32'h0);
    check("rst.diff",   {16'h0, diff},       32'h0);
    check("rst.borrow", {31'h0, borrow_out}, 32'h0);
    check("rst.ovf",    {31'h0, overflow},   32'h0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].bin);
      check($sformatf("vec%0d.busy", i), {31'h0, busy}, 32'h1);
      wait_done(lat);
      check($sformatf("vec%0d.lat", i), lat, 4);
      check_result($sformatf("vec%0d", i), vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d.done_pulse", i), {31'h0, done}, 32'h0);
      check($sformatf("vec%0d.idle", i), {31'h0, busy}, 32'h0);
    end

    // Start while busy with new operands: ignored
    launch(16'h1234, 16'h0234, 1'b0);
    a = 16'hFFFF; b = 16'h0001; bin = 1'b1; start = 1'b1;
    wait_done(lat);
    start = 1'b0;
    check("ign.lat", lat, 4);
    check_result("ign", 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    check("ign.done_pulse", {31'h0, done}, 32'h0);
    check("ign.idle",       {31'h0, busy}, 32'h0);

    // Back-to-back: start accepted in the done cycle
    launch(16'h0000, 16'h0001, 1'b0);
    wait_done(lat);
    check("b2b.lat1", lat, 4);
    check_result("b2b1", 16'hFFFF, 1'b1, 1'b0);
    a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy",      {31'h0, busy}, 32'h1);
    check("b2b.done_low",  {31'h0, done}, 32'h0);
    check("b2b.hold_diff", {16'h0, diff}, 32'hFFFF);
    wait_done(lat);
    check("b2b.lat2", lat, 4);
    check_result("b2b2", 16'h7FFF, 1'b0, 1'b1);

    // Reset asserted at E2 of an operation
    launch(16'h0000, 16'h0001, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst.busy",   {31'h0, busy},       32'h0);
    check("mrst.done",   {31'h0, done},       32'h0);
    check("mrst.diff",   {16'h0, diff},       32'h0);
    check("mrst.borrow", {31'h0, borrow_out}, 32'h0);
    check("mrst.ovf",    {31'h0, overflow},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("mrst.no_done", seen, 0);
    launch(16'h7FFF, 16'hFFFF, 1'b0);
    wait_done(lat);
    check("mrst.lat", lat, 4);
    check_result("mrst.new", 16'h8000, 1'b1, 1'b1);

    // Random operands against the reference model
    for (int n = 0; n < 10000; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h8000;
        1: rb = 16'h7FFF;
        2: rb = ra;
        default: ;
      endcase
      model(ra, rb, rbin, ed, eb, eo);
      launch(ra, rb, rbin);
      wait_done(lat);
      check($sformatf("rnd%0d.lat", n), lat, 4);
      check_result($sformatf("rnd%0d a=%h b=%h bin=%0d", n, ra, rb, rbin), ed, eb, eo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
